// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions for the instruction-fetch stage.
//   fetch_state_e : fetch FSM encoding (IDLE / WAIT / KILL)
//   NOP_INSTR     : instruction word placed in IF/ID when it holds no instruction
//   CPU_RESET_PC  : default first fetch address after reset
//   CPU_PC_STEP   : default sequential PC increment
//   pc_inc()      : sequential next-PC helper (wraps modulo 2^32)
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no request outstanding
      ST_WAIT = 2'd1,   // one request outstanding, its data is wanted
      ST_KILL = 2'd2    // one request outstanding, its data must be dropped
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
   localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] CPU_PC_STEP  = 32'h0000_0004;

   function automatic logic [31:0] pc_inc(input logic [31:0] pc, input logic [31:0] step);
      return pc + step;
   endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// One-entry skid buffer holding an instruction response that arrived while
// the pipeline was stalled.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture instr_i / pc_i and mark the entry valid
//   drain_i    : entry consumed by IF/ID, mark it empty
//   clear_i    : flush the entry (wrong-path work), highest priority
//   instr_i    : instruction word to capture
//   pc_i       : address of instr_i
//   valid_o    : entry holds an instruction
//   instr_o    : buffered instruction
//   pc_o       : address of the buffered instruction
module if_fetch_buf
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic        drain_i,
   input  logic        clear_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   output logic        valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o
);

   logic        valid_q;
   logic [31:0] instr_q;
   logic [31:0] pc_q;

   // Entry storage: clear beats load beats drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         pc_q    <= 32'h0000_0000;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         instr_q <= instr_i;
         pc_q    <= pc_i;
      end else if (drain_i) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_q;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding ID. Owns the PC, issues at most one
// outstanding fetch over a req/gnt + rvalid handshake, parks one response in
// a skid buffer during stalls and drives the IF/ID pipeline register.
// A redirect from ID flushes wrong-path work.
//   clk, rst_n              : clock, asynchronous active-low reset
//   stall                   : hold PC and IF/ID
//   redirect, redirect_pc   : next-PC redirect resolved in ID
//   imem_req/addr/gnt       : fetch request channel (addr = pc)
//   imem_rvalid/rdata       : fetch response channel
//   if_id_valid/instr/pc/pc1: IF/ID register (instr = NOP when invalid)
//   fetch_cnt, flush_cnt    : accepted instructions, effective redirects
module if_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = CPU_RESET_PC,
   parameter logic [31:0] PC_STEP  = CPU_PC_STEP,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             redirect,
   input  logic [31:0]      redirect_pc,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [31:0]      imem_rdata,
   output logic             if_id_valid,
   output logic [31:0]      if_id_instr,
   output logic [31:0]      if_id_pc,
   output logic [31:0]      if_id_pc1,
   output logic [CNT_W-1:0] fetch_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   fetch_state_e     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      req_pc_q, req_pc_d;
   logic             ifid_valid_q, ifid_valid_d;
   logic [31:0]      ifid_instr_q, ifid_instr_d;
   logic [31:0]      ifid_pc_q, ifid_pc_d;
   logic [31:0]      ifid_pc1_q, ifid_pc1_d;
   logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic             redir_eff_s;
   logic             rsp_want_s;
   logic             req_s;
   logic             accept_s;
   logic             fb_load_s;
   logic             fb_drain_s;
   logic             fb_valid_s;
   logic [31:0]      fb_instr_s;
   logic [31:0]      fb_pc_s;

   // Handshake qualifiers. A redirect during a stall is ignored because ID's
   // operands are stale then. The request is combinational so a same-cycle
   // gnt followed by next-cycle rvalid sustains one fetch per cycle.
   always_comb begin
      redir_eff_s = redirect & ~stall;
      rsp_want_s  = (state_q == ST_WAIT) & imem_rvalid;
      req_s       = ~redir_eff_s & ~fb_valid_s &
                    ((state_q == ST_IDLE) | (rsp_want_s & ~stall));
      accept_s    = req_s & imem_gnt;
      // A stall already rules out an effective redirect.
      fb_load_s   = rsp_want_s & stall;
      fb_drain_s  = fb_valid_s & ~stall & ~redir_eff_s;
   end

   if_fetch_buf u_fb (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (fb_load_s),
      .drain_i (fb_drain_s),
      .clear_i (redir_eff_s),
      .instr_i (imem_rdata),
      .pc_i    (req_pc_q),
      .valid_o (fb_valid_s),
      .instr_o (fb_instr_s),
      .pc_o    (fb_pc_s)
   );

   // Fetch FSM next state: tracks whether the outstanding response is wanted.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) state_d = ST_WAIT;
            else          state_d = ST_IDLE;
         end
         ST_WAIT: begin
            if (redir_eff_s)      state_d = imem_rvalid ? ST_IDLE : ST_KILL;
            else if (imem_rvalid) state_d = accept_s ? ST_WAIT : ST_IDLE;
            else                  state_d = ST_WAIT;
         end
         ST_KILL: begin
            if (imem_rvalid) state_d = ST_IDLE;
            else             state_d = ST_KILL;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // PC, IF/ID and counter next state; redirect has the highest priority.
   always_comb begin
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc1_d   = ifid_pc1_q;
      fetch_cnt_d  = fetch_cnt_q;
      flush_cnt_d  = flush_cnt_q;

      if (redir_eff_s)   pc_d = redirect_pc;
      else if (accept_s) pc_d = pc_inc(pc_q, PC_STEP);
      else               pc_d = pc_q;

      if (accept_s) req_pc_d = pc_q;
      else          req_pc_d = req_pc_q;

      if (redir_eff_s) begin
         ifid_valid_d = 1'b0;
         ifid_instr_d = NOP_INSTR;
      end else if (stall) begin
         ifid_valid_d = ifid_valid_q;
      end else if (fb_valid_s) begin
         ifid_valid_d = 1'b1;
         ifid_instr_d = fb_instr_s;
         ifid_pc_d    = fb_pc_s;
         ifid_pc1_d   = pc_inc(fb_pc_s, PC_STEP);
      end else if (rsp_want_s) begin
         ifid_valid_d = 1'b1;
         ifid_instr_d = imem_rdata;
         ifid_pc_d    = req_pc_q;
         ifid_pc1_d   = pc_inc(req_pc_q, PC_STEP);
      end else begin
         // Bubble: pc fields keep their last value.
         ifid_valid_d = 1'b0;
         ifid_instr_d = NOP_INSTR;
      end

      if (rsp_want_s & ~redir_eff_s) fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
      else                           fetch_cnt_d = fetch_cnt_q;

      if (redir_eff_s) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      else             flush_cnt_d = flush_cnt_q;
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         req_pc_q     <= 32'h0000_0000;
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= NOP_INSTR;
         ifid_pc_q    <= 32'h0000_0000;
         ifid_pc1_q   <= 32'h0000_0000;
         fetch_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc1_q   <= ifid_pc1_d;
         fetch_cnt_q  <= fetch_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign imem_req    = req_s;
   assign imem_addr   = pc_q;
   assign if_id_valid = ifid_valid_q;
   assign if_id_instr = ifid_instr_q;
   assign if_id_pc    = ifid_pc_q;
   assign if_id_pc1   = ifid_pc1_q;
   assign fetch_cnt   = fetch_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        if_id_valid;
   logic [31:0] if_id_instr, if_id_pc, if_id_pc1;
   logic [31:0] fetch_cnt, flush_cnt;

   int tests = 0;
   int fails = 0;

   // Instruction memory: one outstanding request, response after 'lat' cycles.
   bit          mem_pend = 1'b0;
   int          mem_left = 0;
   logic [31:0] mem_addr = 32'h0;
   int          lat = 1;

   // Reference model (transaction level).
   logic [31:0] m_pc, m_out_addr;
   bit          m_busy, m_want;
   logic [63:0] m_fb[$];
   bit          m_v;
   logic [31:0] m_instr, m_ipc, m_ipc1, m_fcnt, m_flcnt;

   if_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
      .if_id_pc1(if_id_pc1), .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // Expected request: none during a redirect or while a parked instruction
   // waits; otherwise when nothing is in flight, or when the wanted response
   // arrives this cycle and the pipe is not stalled.
   function automatic bit m_req();
      bit eff;
      eff = redirect & ~stall;
      return !eff && (m_fb.size() == 0) &&
             (!m_busy || (m_want && imem_rvalid && !stall));
   endfunction

   task automatic m_reset();
      m_pc = 32'h0; m_out_addr = 32'h0; m_busy = 0; m_want = 0;
      m_fb.delete(); m_v = 0; m_instr = 0; m_ipc = 0; m_ipc1 = 0;
      m_fcnt = 0; m_flcnt = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; stall = 0; redirect = 0; redirect_pc = 0;
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
      mem_pend = 0; mem_left = 0;
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   // One clock cycle: drive inputs on the falling edge, advance the memory
   // and the reference model at the rising edge, return 1 time unit later.
   task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit g);
      bit          eff, acc, ret;
      logic [31:0] old_pc;
      logic [63:0] e;
      @(negedge clk);
      stall = st; redirect = rd; redirect_pc = rpc;
      imem_rvalid = mem_pend && (mem_left == 0);
      imem_rdata  = imem_rvalid ? word_at(mem_addr) : $urandom;
      imem_gnt    = g && (!mem_pend || imem_rvalid);
      @(posedge clk);
      eff = rd & ~st;
      acc = m_req() && imem_gnt;
      ret = imem_rvalid && m_busy;
      old_pc = m_pc;
      if (eff) begin
         m_pc = rpc; m_fb.delete(); m_v = 0; m_instr = 0; m_flcnt++;
      end else begin
         if (acc) m_pc = m_pc + 32'd4;
         if (!st) begin
            if (m_fb.size() > 0) begin
               e = m_fb.pop_front();
               m_v = 1; m_instr = e[63:32]; m_ipc = e[31:0]; m_ipc1 = e[31:0] + 32'd4;
            end else if (ret && m_want) begin
               m_v = 1; m_instr = imem_rdata; m_ipc = m_out_addr; m_ipc1 = m_out_addr + 32'd4;
            end else begin
               m_v = 0; m_instr = 0;
            end
         end
         if (ret && m_want) begin
            m_fcnt++;
            if (st) m_fb.push_back({imem_rdata, m_out_addr});
         end
      end
      if (ret) m_busy = 0;
      else if (eff && m_busy) m_want = 0;
      if (acc) begin m_busy = 1; m_want = 1; m_out_addr = old_pc; end
      if (imem_rvalid) mem_pend = 0;
      else if (mem_pend) mem_left--;
      if (acc) begin mem_pend = 1; mem_left = lat - 1; mem_addr = old_pc; end
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      lat = 1;
      for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 1);
      @(negedge clk);
      imem_gnt = 0; imem_rvalid = 0;
      #2 rst_n = 1'b0;
      #1;
      m_reset();
      tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", if_id_valid); end
      tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h want 0", imem_addr); end
      tests++; if (fetch_cnt !== 32'h0 || flush_cnt !== 32'h0) begin fails++; $display("FAIL reset_cnt got %0d/%0d want 0/0", fetch_cnt, flush_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL reset_release got req=%0b addr=%h want 1/0", imem_req, imem_addr); end
      // Late response from before the reset must be ignored.
      step(0, 0, 32'h0, 0);
      tests++; if (if_id_valid !== 1'b0 || fetch_cnt !== 32'h0) begin fails++; $display("FAIL late_rvalid got v=%0b cnt=%0d want 0/0", if_id_valid, fetch_cnt); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] ep;
      do_reset();
      lat = 1;
      step(0, 0, 32'h0, 1);
      for (int k = 1; k <= 4; k++) begin
         step(0, 0, 32'h0, 1);
         ep = 32'(4 * (k - 1));
         tests++;
         if (if_id_valid !== 1'b1 || if_id_pc !== ep || if_id_pc1 !== ep + 32'd4 || if_id_instr !== word_at(ep)) begin
            fails++;
            $display("FAIL zero_wait_%0d got v=%0b pc=%h pc1=%h ins=%h want 1 %h %h %h",
                     k, if_id_valid, if_id_pc, if_id_pc1, if_id_instr, ep, ep + 32'd4, word_at(ep));
         end
      end
      tests++; if (fetch_cnt !== 32'd4) begin fails++; $display("FAIL zero_wait_cnt got %0d want 4", fetch_cnt); end
   endtask

   task automatic test_stall();
      do_reset();
      lat = 1;
      step(0, 0, 32'h0, 1);
      step(0, 0, 32'h0, 1);
      step(0, 0, 32'h0, 1);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 32'h0, 1);
         tests++;
         if (if_id_pc !== 32'd4 || if_id_valid !== 1'b1 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL stall_hold_%0d got pc=%h v=%0b req=%0b want 4 1 0", i, if_id_pc, if_id_valid, imem_req);
         end
      end
      step(0, 0, 32'h0, 0);
      tests++;
      if (if_id_pc !== 32'd8 || if_id_instr !== word_at(32'd8) || imem_addr !== 32'd12 || imem_req !== 1'b1) begin
         fails++;
         $display("FAIL stall_release got pc=%h ins=%h addr=%h req=%0b want 8 %h 12 1",
                  if_id_pc, if_id_instr, imem_addr, imem_req, word_at(32'd8));
      end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      lat = 3;
      step(0, 0, 32'h0, 1);
      step(0, 0, 32'h0, 0);
      step(0, 1, 32'h40, 0);
      tests++;
      if (if_id_valid !== 1'b0 || flush_cnt !== 32'd1 || imem_req !== 1'b0) begin
         fails++;
         $display("FAIL redir_wait got v=%0b flush=%0d req=%0b want 0 1 0", if_id_valid, flush_cnt, imem_req);
      end
      step(0, 0, 32'h0, 0);
      tests++;
      if (if_id_valid !== 1'b0 || fetch_cnt !== 32'd0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         fails++;
         $display("FAIL redir_kill got v=%0b fetch=%0d req=%0b addr=%h want 0 0 1 40",
                  if_id_valid, fetch_cnt, imem_req, imem_addr);
      end
   endtask

   task automatic test_redirect_stalled();
      do_reset();
      lat = 1;
      for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1);
      step(1, 1, 32'h80, 1);
      tests++;
      if (if_id_pc !== 32'd4 || flush_cnt !== 32'd0 || imem_addr !== 32'd12) begin
         fails++;
         $display("FAIL redir_stalled got pc=%h flush=%0d addr=%h want 4 0 c", if_id_pc, flush_cnt, imem_addr);
      end
      step(0, 0, 32'h0, 0);
      tests++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'd8) begin
         fails++;
         $display("FAIL redir_stalled_fb got v=%0b pc=%h want 1 8", if_id_valid, if_id_pc);
      end
   endtask

   task automatic test_redirect_rvalid();
      do_reset();
      lat = 1;
      step(0, 0, 32'h0, 1);
      step(0, 1, 32'h40, 0);
      tests++;
      if (if_id_valid !== 1'b0 || fetch_cnt !== 32'd0 || flush_cnt !== 32'd1) begin
         fails++;
         $display("FAIL redir_rvalid got v=%0b fetch=%0d flush=%0d want 0 0 1", if_id_valid, fetch_cnt, flush_cnt);
      end
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 32'h0, 0);
         tests++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            fails++;
            $display("FAIL req_hold_%0d got req=%0b addr=%h want 1 40", i, imem_req, imem_addr);
         end
      end
      step(0, 0, 32'h0, 1);
      tests++;
      if (imem_addr !== 32'h44) begin fails++; $display("FAIL pc_on_gnt got %h want 44", imem_addr); end
   endtask

   task automatic test_random();
      bit          st, rd, g;
      logic [31:0] rpc;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         st  = ($urandom % 4) == 0;
         rd  = ($urandom % 10) == 0;
         g   = ($urandom % 10) < 6;
         rpc = $urandom & 32'hFFFF_FFFC;
         lat = 1 + int'($urandom % 3);
         step(st, rd, rpc, g);
         tests++;
         if (imem_req !== m_req() || imem_addr !== m_pc) begin
            fails++;
            $display("FAIL rnd_req cyc %0d got %0b/%h want %0b/%h", i, imem_req, imem_addr, m_req(), m_pc);
         end
         tests++;
         if (if_id_valid !== m_v || if_id_instr !== m_instr) begin
            fails++;
            $display("FAIL rnd_ifid cyc %0d got %0b/%h want %0b/%h", i, if_id_valid, if_id_instr, m_v, m_instr);
         end
         tests++;
         if (if_id_pc !== m_ipc || if_id_pc1 !== m_ipc1) begin
            fails++;
            $display("FAIL rnd_pc cyc %0d got %h/%h want %h/%h", i, if_id_pc, if_id_pc1, m_ipc, m_ipc1);
         end
         tests++;
         if (fetch_cnt !== m_fcnt || flush_cnt !== m_flcnt) begin
            fails++;
            $display("FAIL rnd_cnt cyc %0d got %0d/%0d want %0d/%0d", i, fetch_cnt, flush_cnt, m_fcnt, m_flcnt);
         end
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_zero_wait();
      test_stall();
      test_redirect_wait();
      test_redirect_stalled();
      test_redirect_rvalid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
